// File: rtl/alu_op_scheduler.sv
// Round-robin scheduler that shares one floating-point ALU between NUM_REQ requesters.
// Optional WAIT-state watchdog enabled by defining ALU_SCHED_TIMEOUT_EN.
module alu_op_scheduler #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_op_a,
  input  logic [32*NUM_REQ-1:0]  req_op_b,
  input  logic [3*NUM_REQ-1:0]   req_op_code,
  input  logic [NUM_REQ-1:0]     req_mode_fp,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_id,
  output logic [31:0]            rsp_result,
  output logic [4:0]             rsp_flags,
  output logic                   rsp_timeout,
  output logic                   busy,
  output logic [31:0]            alu_op_a,
  output logic [31:0]            alu_op_b,
  output logic [2:0]             alu_op_code,
  output logic                   alu_mode_fp,
  output logic                   alu_start,
  input  logic [31:0]            alu_result,
  input  logic                   alu_valid_out,
  input  logic [4:0]             alu_flags
);

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("alu_op_scheduler: NUM_REQ must be 2..4 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [4:0] FLAGS_INVALID = 5'b10000;

  state_t      state, state_next;
  logic [1:0]  rr_ptr;
  logic [1:0]  grant_id;
  logic        grant_valid;
  logic        accept;
  logic        to_expire;
  logic [31:0] raw_a, raw_b, sel_a, sel_b;
  logic [2:0]  sel_code;
  logic        sel_mode;

  // Scan from the RR pointer downwards in priority so the nearest requester wins.
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 2'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        grant_valid = 1'b1;
        grant_id    = 2'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign accept   = (state == S_IDLE) && grant_valid;
  assign raw_a    = req_op_a[32*int'(grant_id) +: 32];
  assign raw_b    = req_op_b[32*int'(grant_id) +: 32];
  assign sel_code = req_op_code[3*int'(grant_id) +: 3];
  assign sel_mode = req_mode_fp[int'(grant_id)];
  // HP16 operands only carry 16 meaningful bits; clear the upper half.
  assign sel_a    = sel_mode ? raw_a : {16'h0000, raw_a[15:0]};
  assign sel_b    = sel_mode ? raw_b : {16'h0000, raw_b[15:0]};

  always_comb begin
    req_ready = '0;
    if (accept && rst_n) req_ready[int'(grant_id)] = 1'b1;
  end

`ifdef ALU_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == S_ISSUE) begin
      to_cnt <= '0;
    end else if (state == S_WAIT) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Expiry fires on the WAIT cycle whose increment brings the count to TIMEOUT_CYCLES.
  assign to_expire = (state == S_WAIT) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign to_expire = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    alu_start  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (accept) state_next = sel_code[2] ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        alu_start  = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (alu_valid_out || to_expire) state_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath registers; all outputs are required to read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= 2'd0;
      rsp_id      <= 2'd0;
      alu_op_a    <= '0;
      alu_op_b    <= '0;
      alu_op_code <= '0;
      alu_mode_fp <= 1'b0;
      rsp_result  <= '0;
      rsp_flags   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr      <= (grant_id == 2'(NUM_REQ - 1)) ? 2'd0 : grant_id + 2'd1;
        rsp_id      <= grant_id;
        alu_op_a    <= sel_a;
        alu_op_b    <= sel_b;
        alu_op_code <= sel_code;
        alu_mode_fp <= sel_mode;
        if (sel_code[2]) begin
          rsp_result  <= '0;
          rsp_flags   <= FLAGS_INVALID;
          rsp_timeout <= 1'b0;
        end
      end
      if (state == S_WAIT) begin
        if (alu_valid_out) begin
          rsp_result  <= alu_result;
          rsp_flags   <= alu_flags;
          rsp_timeout <= 1'b0;
        end else if (to_expire) begin
          rsp_result  <= '0;
          rsp_flags   <= FLAGS_INVALID;
          rsp_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench for alu_op_scheduler: acts as requesters, response sink and ALU.
// Timeout steps run only when ALU_SCHED_TIMEOUT_EN is defined.
module tb_alu_op_scheduler;

  localparam int NUM_REQ = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_op_a;
  logic [32*NUM_REQ-1:0] req_op_b;
  logic [3*NUM_REQ-1:0]  req_op_code;
  logic [NUM_REQ-1:0]    req_mode_fp;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [31:0]           rsp_result;
  logic [4:0]            rsp_flags;
  logic                  rsp_timeout;
  logic                  busy;
  logic [31:0]           alu_op_a;
  logic [31:0]           alu_op_b;
  logic [2:0]            alu_op_code;
  logic                  alu_mode_fp;
  logic                  alu_start;
  logic [31:0]           alu_result;
  logic                  alu_valid_out;
  logic [4:0]            alu_flags;

  int n_assert  = 0;
  int n_fail    = 0;
  int start_cnt = 0;
  int start_ref;
  int n_wait;

  alu_op_scheduler #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b),
    .req_op_code(req_op_code), .req_mode_fp(req_mode_fp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout),
    .busy(busy),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op_code(alu_op_code),
    .alu_mode_fp(alu_mode_fp), .alu_start(alu_start),
    .alu_result(alu_result), .alu_valid_out(alu_valid_out), .alu_flags(alu_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (alu_start) start_cnt <= start_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] code, input logic mode);
    req_op_a[id*32 +: 32]  = a;
    req_op_b[id*32 +: 32]  = b;
    req_op_code[id*3 +: 3] = code;
    req_mode_fp[id]        = mode;
  endtask

  // Advance to the ISSUE cycle (bounded).
  task automatic wait_start(input string tag);
    int n = 0;
    while (alu_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " alu_start"}, alu_start, 1);
  endtask

  // ALU model: reply lat cycles after the ISSUE negedge with a one-cycle valid_out.
  task automatic alu_reply(input logic [31:0] res, input logic [4:0] flg, input int lat);
    repeat (lat) @(negedge clk);
    alu_valid_out = 1'b1;
    alu_result    = res;
    alu_flags     = flg;
    @(negedge clk);
    alu_valid_out = 1'b0;
    alu_result    = '0;
    alu_flags     = '0;
  endtask

  task automatic take_rsp(input string tag, input logic [1:0] id, input logic [31:0] res,
                          input logic [4:0] flg, input logic to);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " rsp_valid"}, rsp_valid, 1);
    check({tag, " rsp_id"}, rsp_id, id);
    check({tag, " rsp_result"}, rsp_result, res);
    check({tag, " rsp_flags"}, rsp_flags, flg);
    check({tag, " rsp_timeout"}, rsp_timeout, to);
    rsp_ready = 1'b1;
    check({tag, " no grant in RESP"}, req_ready, 0);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, " rsp released"}, rsp_valid, 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    req_valid     = '0;
    req_op_a      = '0;
    req_op_b      = '0;
    req_op_code   = '0;
    req_mode_fp   = '0;
    rsp_ready     = 1'b0;
    alu_result    = '0;
    alu_valid_out = 1'b0;
    alu_flags     = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst req_ready", req_ready, 0);
    check("rst rsp_valid", rsp_valid, 0);
    check("rst busy", busy, 0);
    check("rst alu_start", alu_start, 0);
    check("rst alu_op_a", alu_op_a, 0);
    check("rst rsp_timeout", rsp_timeout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Req0 HP16 add, response held until rsp_ready
    set_req(0, 32'h0000_3C00, 32'h0000_3C00, 3'b000, 1'b0);
    req_valid = 2'b01;
    start_ref = start_cnt;
    #1 check("t1 req_ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid = '0;
    check("t1 alu_start", alu_start, 1);
    check("t1 alu_op_a", alu_op_a, 32'h0000_3C00);
    check("t1 alu_op_code", alu_op_code, 3'b000);
    check("t1 busy", busy, 1);
    alu_reply(32'h0000_4000, 5'b00000, 2);
    check("t1 rsp_valid", rsp_valid, 1);
    @(negedge clk);
    check("t1 rsp held", rsp_valid, 1);
    check("t1 result held", rsp_result, 32'h0000_4000);
    take_rsp("t1", 2'd0, 32'h0000_4000, 5'b00000, 1'b0);
    check("t1 start pulses", start_cnt - start_ref, 1);

    // Req1 SP32 mul with rsp_ready raised early
    rsp_ready = 1'b1;
    set_req(1, 32'h3F80_0000, 32'h4000_0000, 3'b010, 1'b1);
    req_valid = 2'b10;
    wait_start("t2");
    req_valid = '0;
    check("t2 alu_op_a", alu_op_a, 32'h3F80_0000);
    check("t2 alu_op_b", alu_op_b, 32'h4000_0000);
    check("t2 alu_op_code", alu_op_code, 3'b010);
    check("t2 alu_mode_fp", alu_mode_fp, 1);
    alu_reply(32'h4000_0000, 5'b00000, 1);
    take_rsp("t2", 2'd1, 32'h4000_0000, 5'b00000, 1'b0);

    // Both requesters valid continuously: grants alternate 0,1,0,1
    set_req(0, 32'h1111_1111, 32'h2222_2222, 3'b000, 1'b1);
    set_req(1, 32'h4040_0000, 32'h3F80_0000, 3'b001, 1'b1);
    req_valid = 2'b11;
    start_ref = start_cnt;
    for (int k = 0; k < 4; k++) begin
      wait_start($sformatf("rr%0d", k));
      check($sformatf("rr%0d alu_op_a", k), alu_op_a,
            (k % 2 == 0) ? 32'h1111_1111 : 32'h4040_0000);
      check($sformatf("rr%0d ready in ISSUE", k), req_ready, 0);
      alu_reply(32'hA0 + 32'(k), 5'(k), 1);
      take_rsp($sformatf("rr%0d", k), 2'(k % 2), 32'hA0 + 32'(k), 5'(k), 1'b0);
    end
    req_valid = '0;
    check("rr start pulses", start_cnt - start_ref, 4);

    // HP16 width rule clears upper operand bits
    set_req(0, 32'hFFFF_3C00, 32'hABCD_0001, 3'b000, 1'b0);
    req_valid = 2'b01;
    wait_start("t4");
    req_valid = '0;
    check("t4 alu_op_a", alu_op_a, 32'h0000_3C00);
    check("t4 alu_op_b", alu_op_b, 32'h0000_0001);
    alu_reply(32'h0000_4000, 5'b00001, 3);
    take_rsp("t4", 2'd0, 32'h0000_4000, 5'b00001, 1'b0);

    // Illegal op_code: straight to RESP without alu_start
    set_req(1, 32'h0000_0001, 32'h0000_0002, 3'b101, 1'b1);
    req_valid = 2'b10;
    start_ref = start_cnt;
    #1 check("t5 req_ready", req_ready, 2'b10);
    @(negedge clk);
    req_valid = '0;
    check("t5 alu_start", alu_start, 0);
    check("t5 rsp_valid", rsp_valid, 1);
    take_rsp("t5", 2'd1, 32'h0, 5'b10000, 1'b0);
    check("t5 no start", start_cnt - start_ref, 0);

`ifdef ALU_SCHED_TIMEOUT_EN
    // Silent ALU: response 8 cycles after entering WAIT
    set_req(0, 32'h0000_1234, 32'h0000_0001, 3'b011, 1'b0);
    req_valid = 2'b01;
    wait_start("to");
    req_valid = '0;
    n_wait = 0;
    while (rsp_valid !== 1'b1 && n_wait < 40) begin
      @(negedge clk);
      n_wait++;
    end
    check("to latency", n_wait, 9);
    take_rsp("to", 2'd0, 32'h0, 5'b10000, 1'b1);

    // valid_out on the expiry cycle wins
    set_req(1, 32'h3F80_0000, 32'h3F80_0000, 3'b000, 1'b1);
    req_valid = 2'b10;
    wait_start("tie");
    req_valid = '0;
    alu_reply(32'h4000_0000, 5'b00001, 8);
    take_rsp("tie", 2'd1, 32'h4000_0000, 5'b00001, 1'b0);
`endif

    // Reset while WAIT: everything returns to zero, stale valid_out ignored
    set_req(0, 32'h0000_5A5A, 32'h0000_0003, 3'b010, 1'b1);
    req_valid = 2'b01;
    wait_start("rw");
    req_valid = '0;
    repeat (5) @(negedge clk);
    check("rw still waiting", busy, 1);
    check("rw no rsp", rsp_valid, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rw busy", busy, 0);
    check("rw alu_start", alu_start, 0);
    check("rw alu_op_a", alu_op_a, 0);
    check("rw alu_mode_fp", alu_mode_fp, 0);
    check("rw rsp_valid", rsp_valid, 0);
    check("rw rsp_result", rsp_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    alu_valid_out = 1'b1;
    alu_result    = 32'hDEAD_BEEF;
    @(negedge clk);
    alu_valid_out = 1'b0;
    alu_result    = '0;
    check("rw stale valid rsp", rsp_valid, 0);
    check("rw stale valid busy", busy, 0);
    check("rw stale result", rsp_result, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
